// File: rtl/seg7_pkg.sv
// ----------------------------------------------------------------------------
// seg7_pkg
//   Shared constants and helpers for the BCD counter / 7-segment display path.
//   - SEG_DIGIT : active-low {g..a} patterns for decimal digits 0..9
//   - SEG_BLANK : all segments off
//   - to_bcd    : elaboration-time int -> packed BCD (up to MAX_DIGITS digits)
//   - seg_of    : nibble -> segment pattern (non-decimal nibbles show blank)
// ----------------------------------------------------------------------------
package seg7_pkg;

    localparam int MAX_DIGITS = 8;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    localparam logic [6:0] SEG_DIGIT [0:9] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
        7'h12, 7'h02, 7'h78, 7'h00, 7'h10
    };

    // Used only on parameters, so the division/modulo never reaches hardware.
    function automatic logic [4*MAX_DIGITS-1:0] to_bcd(input int v);
        int r;
        r = v;
        to_bcd = '0;
        for (int i = 0; i < MAX_DIGITS; i++) begin
            to_bcd[4*i +: 4] = 4'(r % 10);
            r = r / 10;
        end
    endfunction

    function automatic logic [6:0] seg_of(input logic [3:0] d);
        if (d <= 4'd9) begin
            return SEG_DIGIT[int'(d)];
        end
        return SEG_BLANK;
    endfunction

endpackage

// File: rtl/seg7_decode.sv
// ----------------------------------------------------------------------------
// seg7_decode
//   Combinational single-digit decoder, one instance per display.
//   Ports:
//     digit  in  4  BCD digit
//     blank  in  1  force all segments off
//     seg    out 7  active-low segments {g..a}
// ----------------------------------------------------------------------------
module seg7_decode
    import seg7_pkg::*;
(
    input  logic [3:0] digit,
    input  logic       blank,
    output logic [6:0] seg
);

    always_comb begin
        seg = blank ? SEG_BLANK : seg_of(digit);
    end

endmodule

// File: rtl/bcd_range_counter_seg.sv
// ----------------------------------------------------------------------------
// bcd_range_counter_seg
//   N-digit decimal counter stepping between MIN_VAL and MAX_VAL once per
//   prescaler tick, with wrap/saturate, parallel BCD load, synchronous clear
//   and registered active-low 7-segment output.
//   Ports:
//     clk, rst           clock, asynchronous active-high reset
//     en, up_dn          step enable (sampled on tick) and direction
//     clr, load          synchronous clear / load (clr wins over load)
//     load_val           BCD value to load, digit 0 in [3:0]
//     value              current BCD count
//     seg                active-low segments, digit 0 in [6:0], 1 clk behind value
//     tick_o             prescaler tick (one cycle every DIV clocks)
//     bound_o            one-cycle pulse after a step taken from a bound
//     load_err           one-cycle pulse after a rejected load
// ----------------------------------------------------------------------------
module bcd_range_counter_seg
    import seg7_pkg::*;
#(
    parameter int CLK_HZ   = 50_000_000,
    parameter int TICK_HZ  = 1,
    parameter int N_DIGITS = 2,
    parameter int MIN_VAL  = 0,
    parameter int MAX_VAL  = 99,
    parameter int WRAP     = 1,
    parameter int LZB      = 0
)(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  up_dn,
    input  logic                  clr,
    input  logic                  load,
    input  logic [4*N_DIGITS-1:0] load_val,
    output logic [4*N_DIGITS-1:0] value,
    output logic [7*N_DIGITS-1:0] seg,
    output logic                  tick_o,
    output logic                  bound_o,
    output logic                  load_err
);

    localparam int DIV = CLK_HZ / TICK_HZ;
    localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int VW  = 4 * N_DIGITS;
    localparam int SW  = 7 * N_DIGITS;

    localparam logic [PW-1:0] CNT_LAST = PW'(DIV - 1);

    localparam logic [4*MAX_DIGITS-1:0] MIN_ALL = to_bcd(MIN_VAL);
    localparam logic [4*MAX_DIGITS-1:0] MAX_ALL = to_bcd(MAX_VAL);
    localparam logic [VW-1:0]           MIN_BCD = MIN_ALL[VW-1:0];
    localparam logic [VW-1:0]           MAX_BCD = MAX_ALL[VW-1:0];

    // A digit is blanked when LZB is on, it is not digit 0, and it and every
    // digit above it are zero.
    function automatic logic [N_DIGITS-1:0] blank_mask(input logic [VW-1:0] v);
        logic hi_zero;
        hi_zero    = 1'b1;
        blank_mask = '0;
        for (int i = N_DIGITS - 1; i >= 0; i--) begin
            if (v[4*i +: 4] != 4'd0) begin
                hi_zero = 1'b0;
            end
            blank_mask[i] = (LZB != 0) && (i != 0) && hi_zero;
        end
    endfunction

    function automatic logic [SW-1:0] seg_encode(input logic [VW-1:0] v);
        logic [N_DIGITS-1:0] m;
        m = blank_mask(v);
        seg_encode = '0;
        for (int i = 0; i < N_DIGITS; i++) begin
            seg_encode[7*i +: 7] = m[i] ? SEG_BLANK : seg_of(v[4*i +: 4]);
        end
    endfunction

    // Display state while in reset must already show MIN_VAL.
    localparam logic [SW-1:0] SEG_RST = seg_encode(MIN_BCD);

    logic [PW-1:0]       cnt_q, cnt_d;
    logic [VW-1:0]       value_q, value_d;
    logic [SW-1:0]       seg_q, seg_d;
    logic                bound_q, bound_d;
    logic                load_err_q, load_err_d;

    logic                tick;
    logic                step;
    logic                load_ok;
    logic                at_max, at_min;
    logic                carry, borrow;
    logic [VW-1:0]       inc_v, dec_v;
    logic [N_DIGITS-1:0] blank_v;

    // ---------------- prescaler ----------------
    always_comb begin
        tick  = (cnt_q == CNT_LAST);
        cnt_d = tick ? '0 : cnt_q + 1'b1;
    end

    // ---------------- BCD ripple +1 / -1 ----------------
    // Only valid BCD ever reaches value_q, so no digit exceeds 9 here.
    always_comb begin
        inc_v  = value_q;
        dec_v  = value_q;
        carry  = 1'b1;
        borrow = 1'b1;
        for (int i = 0; i < N_DIGITS; i++) begin
            if (carry) begin
                if (value_q[4*i +: 4] == 4'd9) begin
                    inc_v[4*i +: 4] = 4'd0;
                end else begin
                    inc_v[4*i +: 4] = value_q[4*i +: 4] + 4'd1;
                    carry = 1'b0;
                end
            end
            if (borrow) begin
                if (value_q[4*i +: 4] == 4'd0) begin
                    dec_v[4*i +: 4] = 4'd9;
                end else begin
                    dec_v[4*i +: 4] = value_q[4*i +: 4] - 4'd1;
                    borrow = 1'b0;
                end
            end
        end
    end

    // ---------------- load validation ----------------
    // With every nibble a decimal digit, unsigned compare of the packed BCD
    // vectors orders them exactly like the decimal values.
    always_comb begin
        load_ok = 1'b1;
        for (int i = 0; i < N_DIGITS; i++) begin
            if (load_val[4*i +: 4] > 4'd9) begin
                load_ok = 1'b0;
            end
        end
        if ((load_val < MIN_BCD) || (load_val > MAX_BCD)) begin
            load_ok = 1'b0;
        end
    end

    // ---------------- next value: clr > load > step ----------------
    always_comb begin
        value_d    = value_q;
        bound_d    = 1'b0;
        load_err_d = 1'b0;
        at_max     = (value_q == MAX_BCD);
        at_min     = (value_q == MIN_BCD);
        step       = tick && en && !clr && !load;

        if (clr) begin
            value_d = MIN_BCD;
        end else if (load) begin
            if (load_ok) begin
                value_d = load_val;
            end else begin
                load_err_d = 1'b1;
            end
        end else if (step) begin
            if (up_dn) begin
                if (at_max) begin
                    bound_d = 1'b1;
                    if (WRAP != 0) begin
                        value_d = MIN_BCD;
                    end
                end else begin
                    value_d = inc_v;
                end
            end else begin
                if (at_min) begin
                    bound_d = 1'b1;
                    if (WRAP != 0) begin
                        value_d = MAX_BCD;
                    end
                end else begin
                    value_d = dec_v;
                end
            end
        end
    end

    // ---------------- display ----------------
    always_comb begin
        blank_v = blank_mask(value_q);
    end

    for (genvar g = 0; g < N_DIGITS; g++) begin : g_dec
        seg7_decode u_dec (
            .digit (value_q[4*g +: 4]),
            .blank (blank_v[g]),
            .seg   (seg_d[7*g +: 7])
        );
    end

    // ---------------- registers ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q      <= '0;
            value_q    <= MIN_BCD;
            seg_q      <= SEG_RST;
            bound_q    <= 1'b0;
            load_err_q <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            value_q    <= value_d;
            seg_q      <= seg_d;
            bound_q    <= bound_d;
            load_err_q <= load_err_d;
        end
    end

    assign value    = value_q;
    assign seg      = seg_q;
    assign tick_o   = tick;
    assign bound_o  = bound_q;
    assign load_err = load_err_q;

endmodule

// File: tb/tb_bcd_range_counter_seg.sv
// Directed bench: A = wrapping 05..14, B = saturating 05..14, C = 3-digit LZB.
module tb_bcd_range_counter_seg;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic        en_a = 0, up_a = 0, clr_a = 0, load_a = 0;
    logic [7:0]  lv_a = 0;
    logic [7:0]  value_a;
    logic [13:0] seg_a;
    logic        tick_a, bound_a, lerr_a;

    logic        en_b = 0, up_b = 0, clr_b = 0, load_b = 0;
    logic [7:0]  lv_b = 0;
    logic [7:0]  value_b;
    logic [13:0] seg_b;
    logic        tick_b, bound_b, lerr_b;

    logic        en_c = 0, up_c = 0, clr_c = 0, load_c = 0;
    logic [11:0] lv_c = 0;
    logic [11:0] value_c;
    logic [20:0] seg_c;
    logic        tick_c, bound_c, lerr_c;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    bcd_range_counter_seg #(.CLK_HZ(10), .TICK_HZ(1), .N_DIGITS(2), .MIN_VAL(5),
                            .MAX_VAL(14), .WRAP(1), .LZB(0)) dut_a (
        .clk(clk), .rst(rst), .en(en_a), .up_dn(up_a), .clr(clr_a), .load(load_a),
        .load_val(lv_a), .value(value_a), .seg(seg_a), .tick_o(tick_a),
        .bound_o(bound_a), .load_err(lerr_a));

    bcd_range_counter_seg #(.CLK_HZ(10), .TICK_HZ(1), .N_DIGITS(2), .MIN_VAL(5),
                            .MAX_VAL(14), .WRAP(0), .LZB(0)) dut_b (
        .clk(clk), .rst(rst), .en(en_b), .up_dn(up_b), .clr(clr_b), .load(load_b),
        .load_val(lv_b), .value(value_b), .seg(seg_b), .tick_o(tick_b),
        .bound_o(bound_b), .load_err(lerr_b));

    bcd_range_counter_seg #(.CLK_HZ(10), .TICK_HZ(1), .N_DIGITS(3), .MIN_VAL(0),
                            .MAX_VAL(999), .WRAP(1), .LZB(1)) dut_c (
        .clk(clk), .rst(rst), .en(en_c), .up_dn(up_c), .clr(clr_c), .load(load_c),
        .load_val(lv_c), .value(value_c), .seg(seg_c), .tick_o(tick_c),
        .bound_o(bound_c), .load_err(lerr_c));

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    function automatic logic [6:0] enc(input int d);
        case (d)
            0: return 7'h40;  1: return 7'h79;  2: return 7'h24;  3: return 7'h30;
            4: return 7'h19;  5: return 7'h12;  6: return 7'h02;  7: return 7'h78;
            8: return 7'h00;  9: return 7'h10;
            default: return 7'h7F;
        endcase
    endfunction

    function automatic logic [7:0] bcd2(input int v);
        return {4'(v / 10), 4'(v % 10)};
    endfunction

    function automatic logic [13:0] seg2(input int v);
        return {enc(v / 10), enc(v % 10)};
    endfunction

    // Stops at the negedge where the selected tick is high (bounded).
    task automatic wait_tick(input int which);
        int n;
        n = 0;
        while (((which == 0) ? tick_a : tick_b) !== 1'b1 && n < 25) begin
            @(negedge clk);
            n++;
        end
        chk("tick_timeout", {31'd0, (which == 0) ? tick_a : tick_b}, 32'd1);
    endtask

    logic [7:0]  bad_lv [3] = '{8'h1A, 8'h20, 8'h04};
    logic [11:0] c_lv   [3] = '{12'h007, 12'h105, 12'h020};
    logic [20:0] c_seg  [3] = '{{7'h7F, 7'h7F, 7'h78}, {7'h79, 7'h40, 7'h12},
                                {7'h7F, 7'h24, 7'h40}};

    initial begin
        int n, exp_v, prev;

        // ---- 1: reset mid-period ----
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rst_value", value_a, 8'h05);
        chk("rst_seg", seg_a, {7'h40, 7'h12});
        chk("rst_tick", tick_a, 0);
        chk("rst_bound", bound_a, 0);
        chk("rst_lerr", lerr_a, 0);
        chk("rst_seg_c", seg_c, {7'h7F, 7'h7F, 7'h40});
        @(negedge clk);
        rst = 1'b0;
        n = 1;
        while (!tick_a && n < 25) begin
            @(negedge clk);
            n++;
        end
        chk("first_tick_cycle", n, 10);

        // ---- 2: up, wrap ----
        en_a = 1; up_a = 1;
        prev = 5;
        for (int k = 0; k < 10; k++) begin
            if (k > 0) wait_tick(0);
            @(negedge clk);
            exp_v = (prev == 14) ? 5 : prev + 1;
            chk("up_value", value_a, bcd2(exp_v));
            chk("up_bound", bound_a, (prev == 14) ? 1 : 0);
            @(negedge clk);
            chk("up_seg", seg_a, seg2(exp_v));
            prev = exp_v;
        end
        en_a = 0;

        // ---- 3: down, saturate ----
        load_b = 1; lv_b = 8'h06;
        @(negedge clk);
        load_b = 0;
        chk("b_load", value_b, 8'h06);
        en_b = 1; up_b = 0;
        for (int k = 0; k < 3; k++) begin
            wait_tick(1);
            @(negedge clk);
            chk("sat_value", value_b, 8'h05);
            chk("sat_bound", bound_b, (k > 0) ? 1 : 0);
        end
        @(negedge clk);
        chk("bound_one_cycle", bound_b, 0);
        en_b = 0;

        // ---- 4: load beats step; rejected loads ----
        en_a = 1; up_a = 1;
        wait_tick(0);
        load_a = 1; lv_a = 8'h09;
        @(negedge clk);
        load_a = 0; en_a = 0;
        chk("load_over_step", value_a, 8'h09);
        chk("load_no_bound", bound_a, 0);
        chk("load_ok_no_err", lerr_a, 0);
        for (int k = 0; k < 3; k++) begin
            load_a = 1; lv_a = bad_lv[k];
            @(negedge clk);
            load_a = 0;
            chk("bad_load_value", value_a, 8'h09);
            chk("bad_load_err", lerr_a, 1);
            @(negedge clk);
            chk("bad_load_err_end", lerr_a, 0);
        end

        // ---- 5: clr beats load; carry and borrow ----
        clr_a = 1; load_a = 1; lv_a = 8'h12;
        @(negedge clk);
        clr_a = 0; load_a = 0;
        chk("clr_over_load", value_a, 8'h05);
        load_a = 1; lv_a = 8'h09;
        @(negedge clk);
        load_a = 0;
        en_a = 1; up_a = 1;
        wait_tick(0);
        @(negedge clk);
        chk("carry_09_10", value_a, 8'h10);
        up_a = 0;
        wait_tick(0);
        @(negedge clk);
        chk("borrow_10_09", value_a, 8'h09);
        en_a = 0;
        load_a = 1; lv_a = 8'h05;
        @(negedge clk);
        load_a = 0;
        en_a = 1;
        wait_tick(0);
        @(negedge clk);
        chk("down_wrap_value", value_a, 8'h14);
        chk("down_wrap_bound", bound_a, 1);
        en_a = 0;

        // ---- 6: 3 digits, leading-zero blanking ----
        for (int k = 0; k < 3; k++) begin
            load_c = 1; lv_c = c_lv[k];
            @(negedge clk);
            load_c = 0;
            chk("c_value", value_c, c_lv[k]);
            @(negedge clk);
            chk("c_seg_lzb", seg_c, c_seg[k]);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
